// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with a single IRQ line.
// Define TIMER_PRESCALE_EN to add the PRESCALE register and tick divider.
`timescale 1ns/1ps
module timer_counter #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Addr,
    input  logic             WE,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_PRESC  = 2'd3;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic             irq_pend;
    logic             pend_nxt;
    logic             fsm_clr_en;
    logic             tick;

    logic [1:0] sel;
    logic       wr_ctrl;
    logic       wr_preset;
    logic       en;
    logic       auto_rl;
    logic       im;

    assign sel       = Addr[3:2];
    assign wr_ctrl   = WE && (sel == A_CTRL);
    assign wr_preset = WE && (sel == A_PRESET);
    assign en        = ctrl[0];
    assign auto_rl   = (ctrl[2:1] == 2'b01);
    assign im        = ctrl[3];

    logic unused_addr;
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] div;
    logic [PRESCALE_W-1:0] div_nxt;
    logic                  wr_presc;

    assign wr_presc = WE && (sel == A_PRESC);
    assign tick     = (div == prescale);

    // Divider restarts on every load and on every COUNT step.
    always_comb begin
        div_nxt = div;
        if (state == LOAD) begin
            div_nxt = '0;
        end else if (state == CNT && en) begin
            div_nxt = tick ? '0 : div + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            div      <= '0;
        end else begin
            div <= div_nxt;
            if (wr_presc) begin
                prescale <= Din[PRESCALE_W-1:0];
            end
        end
    end
`else
    logic [PRESCALE_W-1:0] unused_presc;
    assign unused_presc = '0;
    assign tick         = 1'b1;
`endif

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        pend_nxt   = irq_pend;
        fsm_clr_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (count > WIDTH'(1)) begin
                        count_nxt = count - WIDTH'(1);
                    end else begin
                        count_nxt = '0;
                        pend_nxt  = 1'b1;
                        state_nxt = INT;
                    end
                end
            end
            INT: begin
                if (auto_rl) begin
                    pend_nxt  = 1'b0;
                    state_nxt = en ? LOAD : IDLE;
                end else begin
                    fsm_clr_en = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A CPU write to CTRL always acknowledges the pending interrupt.
        if (wr_ctrl) begin
            pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            irq_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            irq_pend <= pend_nxt;
        end
    end

    // The CPU write takes priority over the one-shot auto-clear of EN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl <= Din[3:0];
        end else if (fsm_clr_en) begin
            ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= '0;
        end else if (wr_preset) begin
            preset <= Din;
        end
    end

    always_comb begin
        Dout = '0;
        unique case (sel)
            A_CTRL:   Dout[3:0] = ctrl;
            A_PRESET: Dout      = preset;
            A_COUNT:  Dout      = count;
            A_PRESC: begin
`ifdef TIMER_PRESCALE_EN
                Dout = WIDTH'(prescale);
`else
                Dout = '0;
`endif
            end
            default:  Dout      = '0;
        endcase
    end

    assign IRQ = im & irq_pend;

endmodule
